debug_dump_tx: RTL



---
 rtl/debug_dump_tx.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: sends machine state (PC, register file, data memory) to the
// host over a byte-wide UART transmit handshake, MSB byte of each word first.
// Optional build macro DUMP_CHECKSUM_EN appends one XOR checksum byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a halt pulse on start_i
// ADDR     | debug address driven for the current segment/index
// FETCH    | read data valid, latched into the word buffer
// SEND     | tx_start_o strobe with the current byte
// WAIT_TX  | byte held on tx_data_o until tx_done_i
// NEXT     | advance PC -> REG -> MEM -> end of stream
// CSUM     | checksum byte queued (DUMP_CHECKSUM_EN only)
// DONE     | done_o pulse, busy_o drops next cycle
module debug_dump_tx #(
    parameter int NB_DATA    = 32,
    parameter int N_BITS     = 8,
    parameter int NB_REG     = 5,
    parameter int N_REGISTER = 32,
    parameter int NB_ADDR    = 7,
    parameter int MEM_WORDS  = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_i,
    input  logic [NB_ADDR-1:0]  pc_i,
    output logic [NB_REG-1:0]   reg_addr_o,
    input  logic [NB_DATA-1:0]  reg_data_i,
    output logic                select_reg_o,
    output logic [NB_ADDR-1:0]  mem_addr_o,
    input  logic [NB_DATA-1:0]  mem_data_i,
    output logic                select_mem_o,
    output logic [N_BITS-1:0]   tx_data_o,
    output logic                tx_start_o,
    input  logic                tx_done_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam int N_BYTES = NB_DATA / N_BITS;
    localparam int NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);
    localparam logic [NB_REG-1:0]  LAST_REG  = NB_REG'(N_REGISTER - 1);
    localparam logic [NB_ADDR-1:0] LAST_MEM  = NB_ADDR'(MEM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_FETCH,
        ST_SEND,
        ST_WAIT_TX,
        ST_NEXT,
`ifdef DUMP_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SEG_PC,
        SEG_REG,
        SEG_MEM
    } seg_t;

    state_t               state_q;
    seg_t                 seg_q;
    logic [NB_DATA-1:0]   word_q;
    logic [NB_BIDX-1:0]   byte_idx_q;
    logic [NB_REG-1:0]    reg_addr_q;
    logic [NB_ADDR-1:0]   mem_addr_q;
    logic                 sel_reg_q;
    logic                 sel_mem_q;
    logic [N_BITS-1:0]    tx_data_q;
    logic                 tx_start_q;
    logic                 busy_q;
    logic                 done_q;
`ifdef DUMP_CHECKSUM_EN
    logic [N_BITS-1:0]    csum_q;
    logic                 csum_phase_q;
`endif

    logic [NB_DATA-1:0]   pc_word;
    logic [NB_DATA-1:0]   fetched_word;

    assign pc_word      = NB_DATA'(pc_i);
    assign fetched_word = (seg_q == SEG_MEM) ? mem_data_i : reg_data_i;

    // Byte idx of a word counted from the MSB end.
    function automatic logic [N_BITS-1:0] byte_of(input logic [NB_DATA-1:0] w,
                                                  input logic [NB_BIDX-1:0] idx);
        logic [NB_DATA-1:0] sh;
        sh = w << (N_BITS * int'(idx));
        return sh[NB_DATA-1 -: N_BITS];
    endfunction

    // Dump sequencer; the byte and strobe are loaded on entry to SEND so the
    // strobe lines up with the SEND cycle and the byte stays put in WAIT_TX.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            seg_q        <= SEG_PC;
            word_q       <= '0;
            byte_idx_q   <= '0;
            reg_addr_q   <= '0;
            mem_addr_q   <= '0;
            sel_reg_q    <= 1'b0;
            sel_mem_q    <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    sel_reg_q <= 1'b0;
                    sel_mem_q <= 1'b0;
                    if (start_i) begin
                        word_q     <= pc_word;
                        seg_q      <= SEG_PC;
                        byte_idx_q <= '0;
                        tx_data_q  <= byte_of(pc_word, '0);
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        csum_q       <= '0;
                        csum_phase_q <= 1'b0;
`endif
                        state_q    <= ST_SEND;
                    end
                end
                ST_ADDR: state_q <= ST_FETCH;
                ST_FETCH: begin
                    word_q     <= fetched_word;
                    byte_idx_q <= '0;
                    tx_data_q  <= byte_of(fetched_word, '0);
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
`ifdef DUMP_CHECKSUM_EN
                    csum_q <= csum_q ^ tx_data_q;
`endif
                    state_q <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (tx_done_i) begin
`ifdef DUMP_CHECKSUM_EN
                        if (csum_phase_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else
`endif
                        if (byte_idx_q == LAST_BYTE) begin
                            state_q <= ST_NEXT;
                        end else begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            tx_data_q  <= byte_of(word_q, byte_idx_q + 1'b1);
                            tx_start_q <= 1'b1;
                            state_q    <= ST_SEND;
                        end
                    end
                end
                ST_NEXT: begin
                    unique case (seg_q)
                        SEG_PC: begin
                            seg_q      <= SEG_REG;
                            reg_addr_q <= '0;
                            sel_reg_q  <= 1'b1;
                            state_q    <= ST_ADDR;
                        end
                        SEG_REG: begin
                            if (reg_addr_q == LAST_REG) begin
                                seg_q      <= SEG_MEM;
                                sel_reg_q  <= 1'b0;
                                sel_mem_q  <= 1'b1;
                                mem_addr_q <= '0;
                            end else begin
                                reg_addr_q <= reg_addr_q + 1'b1;
                            end
                            state_q <= ST_ADDR;
                        end
                        default: begin
                            if (mem_addr_q == LAST_MEM) begin
                                sel_mem_q <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                                state_q   <= ST_CSUM;
`else
                                done_q    <= 1'b1;
                                state_q   <= ST_DONE;
`endif
                            end else begin
                                mem_addr_q <= mem_addr_q + 1'b1;
                                state_q    <= ST_ADDR;
                            end
                        end
                    endcase
                end
`ifdef DUMP_CHECKSUM_EN
                ST_CSUM: begin
                    tx_data_q    <= csum_q;
                    tx_start_q   <= 1'b1;
                    csum_phase_q <= 1'b1;
                    state_q      <= ST_SEND;
                end
`endif
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign reg_addr_o   = reg_addr_q;
    assign mem_addr_o   = mem_addr_q;
    assign select_reg_o = sel_reg_q;
    assign select_mem_o = sel_mem_q;
    assign tx_data_o    = tx_data_q;
    assign tx_start_o   = tx_start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule
